vga_frame_checker: RTL and testbench
====================================

# vga_frame_checker

Synthesizable sink for the TinyVGA PMOD stream driven on `uo_out` by the nyancat top level. It samples the 8-bit pin bus one pixel per clock and recovers sync edges, line and frame geometry, and sync pulse widths. It also computes a per-frame CRC over active-region pixels. It is instantiated in the testbench and on the FPGA bring-up board, so cocotb tests and hardware runs check the video output against the same numbers.

## Interface
Parameters:
- `H_TOTAL`, 800, expected clocks per line.
- `H_START`, 144, first active pixel position, counted from the hsync falling edge (sync 96 + back porch 48).
- `H_ACTIVE`, 640, active pixels per line.
- `V_TOTAL`, 525, expected lines per frame.
- `V_START`, 35, first active line, counted from the vsync falling edge (sync 2 + back porch 33).
- `V_ACTIVE`, 480, active lines per frame.

Ports:
- `clk`  in  1  pixel clock; one sample per cycle.
- `rst_n`  in  1  asynchronous active-low reset.
- `vga_in`  in  8  TinyVGA pins: [0]=R1, [1]=G1, [2]=B1, [3]=VS, [4]=R0, [5]=G0, [6]=B0, [7]=HS. Both syncs are active-low.
- `locked`  out  1  set at the first vsync falling edge after reset.
- `line_len`  out  11  clocks between the two most recent hsync falling edges.
- `hsync_w`  out  11  width of the last hsync low pulse, in clocks.
- `frame_lines`  out  10  lines in the last complete frame.
- `vsync_w`  out  10  width of the last vsync low pulse, in lines (hsync falls counted while VS low).
- `frame_crc`  out  16  CRC of the last complete frame.
- `frame_valid`  out  1  one-cycle strobe; `frame_lines` and `frame_crc` have just updated.
- `line_err`  out  1  one-cycle strobe; the latched `line_len` is not equal to `H_TOTAL`.
- `err_sticky`  out  1  set by any `line_err`, or by `frame_valid` with `frame_lines` not equal to `V_TOTAL`; cleared only by reset.

## Operation
- **Input sampling:** `vga_in` is registered once into `s`; `p` holds the previous value of `s`.
  - hfall = `p.HS & ~s.HS`. hrise = `~p.HS & s.HS`. vfall and vrise are defined the same way on VS.
- **Horizontal counter:** `hcnt` is 11 bits, saturates at 2047, and the pixel at hfall has position 0.
  - On hfall: `line_len` <= `hcnt`+1 (saturating), `hcnt` <= 0, hsync-width counter <= 1.
  - On hrise: `hsync_w` <= width counter. The width counter increments while `s.HS` is low and saturates.
- **Vertical counter:** `vline` is 10 bits and saturates at 1023.
  - On vfall: set `vpend`.
  - On each hfall with `vpend`, or with vfall in the same cycle (frame boundary): `vline` <= 0 and `vpend` is cleared.
  - If `locked` is already set at a frame boundary:
    - `frame_lines` <= `vline`+1;
    - `frame_crc` <= running CRC;
    - `frame_valid` pulses;
    - the frame check is evaluated.
  - The running CRC reinitializes at every frame boundary.
  - On any other hfall, `vline` increments.
  - `vsync_w` counts hfalls while `s.VS` is low and is latched on vrise.
- **Locking:** `locked` sets on the first vfall and gates `frame_valid`, `line_err` and `err_sticky`. The partial frame seen after reset is never reported.
- **Active region:** `hcnt` in [H_START, H_START+H_ACTIVE-1] and `vline` in [V_START, V_START+V_ACTIVE-1].
- **Line check:** `line_err` fires on the cycle after an hfall when `locked` is set and the new `line_len` is not equal to `H_TOTAL`.

## Timing
- **Reset values:** all outputs and internal state are 0 during reset, including `p.HS` and `p.VS`.
  - No hfall or vfall can be detected until `s` has held a 1 after reset.
- **Latency, pin to `s`:** 1 clock.
- **Latency, hfall in `s` to updated `line_len`:** 1 clock. `line_err` pulses in the same cycle that `line_len` updates.
- **Frame boundary:** `frame_valid`, `frame_lines` and `frame_crc` update together, 1 clock after the boundary hfall.
- **Simultaneous vfall and hfall:** treated as a frame boundary on that same hfall.
- **vfall with no following hfall:** `vpend` stays set indefinitely.
- **Saturation:** a counter at saturation holds its value. A saturated latched value (2047 or 1023) indicates a lost sync.
- **Reset mid-frame:** asynchronous clear. The first `frame_valid` after reset comes at the second frame boundary.

## Configuration
- Macro: `VGA_CHECK_CRC_EN`.
- **Defined:** CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR).
  - Each active pixel shifts in 6 bits, MSB first, in the order {R1,R0,G1,G0,B1,B0}.
  - Non-active pixels leave the CRC unchanged.
- **Undefined:** CRC logic is omitted and `frame_crc` is tied to 0. All other behaviour is identical.

## Test plan
- **Nominal 640x480 generator, 3 frames:**
  - `line_len`=800, `hsync_w`=96, `vsync_w`=2, `frame_lines`=525.
  - `frame_valid` pulses twice.
  - `line_err`=0 and `err_sticky`=0.
- **One line shortened to 799 clocks:**
  - `line_len`=799 with a one-cycle `line_err`, then `err_sticky`=1.
  - The next line reads 800 again; `err_sticky` stays 1.
- **Frame of 524 lines:** `frame_valid` with `frame_lines`=524 and `err_sticky`=1; `line_err` stays 0.
- **Reset asserted mid-frame, then released:**
  - All outputs read 0.
  - `locked` sets at the next vfall.
  - The first `frame_valid` comes only at the following frame boundary, with `frame_lines`=525.
- **CRC:**
  - All-black frame, then a frame with a single white pixel at (hcnt 144, vline 35).
  - `frame_crc` equals the Python model for each frame, and the two values differ.
  - With `VGA_CHECK_CRC_EN` undefined, `frame_crc`=0.
- **HS held high for 3000 clocks after lock:**
  - The next hfall latches `line_len`=2047.
  - `line_err` pulses.
  - `vline` has not advanced during the stall.

Source files
------------

// File: rtl/vga_frame_checker.sv
// vga_frame_checker
//
// Passive sink for the TinyVGA PMOD pin bus. It samples one pixel per
// clock and recovers the line and frame geometry and the sync pulse widths.
// Optionally it also computes a per-frame CRC over the active-region pixels.
// The testbench and the bring-up board both check the video output against
// these numbers.
//
// Ports:
//   clk          pixel clock, one sample per cycle
//   rst_n        asynchronous active-low reset
//   vga_in[7:0]  TinyVGA pins {HS,B0,G0,R0,VS,B1,G1,R1}; both syncs active-low
//   locked       set at the first vsync falling edge after reset
//   line_len     clocks between the two most recent hsync falling edges
//   hsync_w      width of the last hsync low pulse, in clocks
//   frame_lines  lines in the last complete frame
//   vsync_w      width of the last vsync low pulse, in lines
//   frame_crc    CRC-16-CCITT of the last complete frame's active pixels
//   frame_valid  one-cycle strobe: frame_lines/frame_crc just updated
//   line_err     one-cycle strobe: the latched line_len differs from H_TOTAL
//   err_sticky   any line or frame-length error since reset
//
// Build option:
//   VGA_CHECK_CRC_EN  defined   -> CRC-16-CCITT over active pixels
//                     undefined -> no CRC logic, frame_crc tied to 0
//
// Counter alignment: hcnt and vline describe the pixel held in p, not s.
// The hsync-fall pixel therefore lands at hcnt 0 on the cycle after the fall.

module vga_frame_checker #(
   parameter int H_TOTAL  = 800,
   parameter int H_START  = 144,
   parameter int H_ACTIVE = 640,
   parameter int V_TOTAL  = 525,
   parameter int V_START  = 35,
   parameter int V_ACTIVE = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  vga_in,
   output logic        locked,
   output logic [10:0] line_len,
   output logic [10:0] hsync_w,
   output logic [9:0]  frame_lines,
   output logic [9:0]  vsync_w,
   output logic [15:0] frame_crc,
   output logic        frame_valid,
   output logic        line_err,
   output logic        err_sticky
);

   localparam logic [10:0] hMax      = 11'h7FF;
   localparam logic [9:0]  vMax      = 10'h3FF;
   localparam logic [10:0] hTotalVal = 11'(H_TOTAL);
   localparam logic [10:0] hFirst    = 11'(H_START);
   localparam logic [10:0] hLast     = 11'(H_START + H_ACTIVE - 1);
   localparam logic [9:0]  vTotalVal = 10'(V_TOTAL);
   localparam logic [9:0]  vFirst    = 10'(V_START);
   localparam logic [9:0]  vLast     = 10'(V_START + V_ACTIVE - 1);

   logic [7:0]  s;
   logic [7:0]  p;
   logic        hFall;
   logic        hRise;
   logic        vFall;
   logic        vRise;
   logic        frameBoundary;
   logic        activePix;
   logic [10:0] hcnt;
   logic [10:0] hswCnt;
   logic [10:0] lineLenNext;
   logic [9:0]  vline;
   logic [9:0]  vswCnt;
   logic [9:0]  frameLinesNext;
   logic        vpend;

   // Sync edge detection on the registered pins. Because s and p both reset
   // to 0, no falling edge can be seen until s has held a 1. A frame boundary
   // is the first hsync fall at or after a vsync fall.
   always_comb begin
      hFall          = p[7] & ~s[7];
      hRise          = ~p[7] & s[7];
      vFall          = p[3] & ~s[3];
      vRise          = ~p[3] & s[3];
      frameBoundary  = hFall & (vpend | vFall);
      lineLenNext    = (hcnt == hMax) ? hMax : hcnt + 11'd1;
      frameLinesNext = (vline == vMax) ? vMax : vline + 10'd1;
      activePix      = (hcnt >= hFirst) && (hcnt <= hLast) &&
                       (vline >= vFirst) && (vline <= vLast);
   end

   // Pin sampling: s is the registered bus and p its one-cycle-old copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s <= '0;
         p <= '0;
      end else begin
         s <= vga_in;
         p <= s;
      end
   end

   // Horizontal timing. hcnt and the hsync-width counter both saturate, so
   // a stalled hsync shows up as a latched 2047 instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt     <= '0;
         hswCnt   <= '0;
         line_len <= '0;
         hsync_w  <= '0;
      end else begin
         if (hFall) begin
            hcnt     <= '0;
            hswCnt   <= 11'd1;
            line_len <= lineLenNext;
         end else begin
            if (hcnt != hMax) begin
               hcnt <= hcnt + 11'd1;
            end
            if (!s[7] && hswCnt != hMax) begin
               hswCnt <= hswCnt + 11'd1;
            end
         end
         if (hRise) begin
            hsync_w <= hswCnt;
         end
      end
   end

   // Vertical timing. A vsync fall only arms vpend. The line counter restarts
   // on the next hsync fall, or on the same one when both edges coincide. If
   // no hsync fall ever follows, vpend just stays armed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vline <= '0;
         vpend <= 1'b0;
      end else begin
         if (frameBoundary) begin
            vline <= '0;
            vpend <= 1'b0;
         end else begin
            if (hFall && vline != vMax) begin
               vline <= vline + 10'd1;
            end
            if (vFall) begin
               vpend <= 1'b1;
            end
         end
      end
   end

   // vsync width in lines: count the hsync falls seen while VS is low, and
   // include one that coincides with the vsync fall itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vswCnt  <= '0;
         vsync_w <= '0;
      end else begin
         if (vFall) begin
            vswCnt <= hFall ? 10'd1 : 10'd0;
         end else if (hFall && !s[3] && vswCnt != vMax) begin
            vswCnt <= vswCnt + 10'd1;
         end
         if (vRise) begin
            vsync_w <= vswCnt;
         end
      end
   end

   // Lock and reporting. The frame in progress at lock time started before
   // any boundary was seen, so a frame is only reported once locked was
   // already set at its closing boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked      <= 1'b0;
         frame_lines <= '0;
         frame_valid <= 1'b0;
         line_err    <= 1'b0;
         err_sticky  <= 1'b0;
      end else begin
         if (vFall) begin
            locked <= 1'b1;
         end
         frame_valid <= frameBoundary & locked;
         line_err    <= hFall & locked & (lineLenNext != hTotalVal);
         if (frameBoundary && locked) begin
            frame_lines <= frameLinesNext;
         end
         if ((hFall && locked && lineLenNext != hTotalVal) ||
             (frameBoundary && locked && frameLinesNext != vTotalVal)) begin
            err_sticky <= 1'b1;
         end
      end
   end

`ifdef VGA_CHECK_CRC_EN
   logic [15:0] crcRun;
   logic [15:0] crcNext;
   logic [15:0] frameCrcReg;
   logic [5:0]  pixBits;

   // CRC-16-CCITT, MSB first, six bits per active pixel in the order
   // {R1,R0,G1,G0,B1,B0}. Blanking pixels leave the running value unchanged.
   always_comb begin
      pixBits = {p[0], p[4], p[1], p[5], p[2], p[6]};
      crcNext = crcRun;
      if (activePix) begin
         for (int i = 5; i >= 0; i--) begin
            crcNext = {crcNext[14:0], 1'b0} ^
                      ((crcNext[15] ^ pixBits[i]) ? 16'h1021 : 16'h0000);
         end
      end
   end

   // Running CRC restarts at every frame boundary. The value it held up to
   // that point belongs to the frame that just closed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crcRun      <= '0;
         frameCrcReg <= '0;
      end else if (frameBoundary) begin
         crcRun <= 16'hFFFF;
         if (locked) begin
            frameCrcReg <= crcRun;
         end
      end else begin
         crcRun <= crcNext;
      end
   end

   assign frame_crc = frameCrcReg;
`else
   logic unusedCrcInputs;

   // Without the CRC the colour bits and the active-region decode have no
   // consumer. They are folded into one sink so the omission is deliberate.
   assign unusedCrcInputs = ^{p[6:4], p[2:0], activePix};
   assign frame_crc       = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_checker.sv
// tb_vga_frame_checker
//
// Directed bench for vga_frame_checker. It uses a reduced geometry: 40 clocks
// per line (4 sync, 4 back porch, 24 active, 8 front porch) and 20 lines per
// frame (2 sync, 3 back porch, 10 active, 5 front porch). This keeps each
// frame at 800 clocks.
//
// Each table entry describes one whole frame. The frame starts just after the
// hsync/vsync fall that opens it. It is closed by a 4-pixel tail that opens
// the next frame, and that tail triggers the report for the entry.
// Hand-written sequences cover the reset values, locking, and a mid-frame
// reset.

module tb_vga_frame_checker;

   localparam int HT  = 40;
   localparam int HSW = 4;
   localparam int HS  = 8;
   localparam int HA  = 24;
   localparam int VT  = 20;
   localparam int VSW = 2;
   localparam int VS  = 5;
   localparam int VA  = 10;

`ifdef VGA_CHECK_CRC_EN
   localparam bit CrcOn = 1'b1;
`else
   localparam bit CrcOn = 1'b0;
`endif

   typedef struct {
      int lines;
      int oddLine;
      int oddLen;
      int whiteX;
      int whiteY;
      int noise;
      int expLines;
      int expSticky;
      int expErrs;
      int expErrLen;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  vga_in;
   logic        locked;
   logic [10:0] line_len;
   logic [10:0] hsync_w;
   logic [9:0]  frame_lines;
   logic [9:0]  vsync_w;
   logic [15:0] frame_crc;
   logic        frame_valid;
   logic        line_err;
   logic        err_sticky;

   int          applied     = 0;
   int          miscompares = 0;
   int          fvCount     = 0;
   int          leCount     = 0;
   logic [31:0] lastLines   = '0;
   logic [31:0] lastCrc     = '0;
   logic [31:0] lastErrLen  = '0;
   logic [15:0] modelCrc;
   logic [15:0] crcSeen [7];
   vec_t        vecs [7];

   vga_frame_checker #(
      .H_TOTAL (HT),
      .H_START (HS),
      .H_ACTIVE(HA),
      .V_TOTAL (VT),
      .V_START (VS),
      .V_ACTIVE(VA)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vga_in     (vga_in),
      .locked     (locked),
      .line_len   (line_len),
      .hsync_w    (hsync_w),
      .frame_lines(frame_lines),
      .vsync_w    (vsync_w),
      .frame_crc  (frame_crc),
      .frame_valid(frame_valid),
      .line_err   (line_err),
      .err_sticky (err_sticky)
   );

   // 10 ns pixel clock.
   always #5 clk = ~clk;

   // Strobe monitor: sampled on the falling edge. It keeps running totals of
   // both strobes and the values that accompanied each one.
   always @(negedge clk) begin
      if (frame_valid) begin
         fvCount   = fvCount + 1;
         lastLines = 32'(frame_lines);
         lastCrc   = 32'(frame_crc);
      end
      if (line_err) begin
         leCount    = leCount + 1;
         lastErrLen = 32'(line_len);
      end
   end

   // Watchdog so a stuck run still ends with a diagnostic.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      applied = applied + 1;
      if (actual !== expected) begin
         miscompares = miscompares + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] crcPixel(input logic [15:0] c, input logic [7:0] px);
      logic [15:0] r;
      logic [5:0]  bits;
      logic        fb;
      r    = c;
      bits = {px[0], px[4], px[1], px[5], px[2], px[6]};
      for (int i = 5; i >= 0; i--) begin
         fb = r[15] ^ bits[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   function automatic bit isActive(input int ln, input int pos);
      return (ln >= VS) && (ln < VS + VA) && (pos >= HS) && (pos < HS + HA);
   endfunction

   // The pixel at a frame coordinate. The optional noise lights pixels just
   // outside the active window so they are present but must not enter the CRC.
   function automatic logic [7:0] pixelAt(input int ln, input int pos, input vec_t v);
      logic [7:0] px;
      bit         lit;
      lit = (pos == v.whiteX) && (ln == v.whiteY);
      if (v.noise != 0) begin
         if (pos == HS - 1 || pos == HS + HA) lit = 1'b1;
         if ((ln == VS - 1 || ln == VS + VA) && pos == 20) lit = 1'b1;
      end
      px = lit ? 8'h77 : 8'h00;
      if (pos >= HSW) px = px | 8'h80;
      if (ln >= VSW)  px = px | 8'h08;
      return px;
   endfunction

   task automatic drivePixel(input logic [7:0] px);
      vga_in = px;
      @(negedge clk);
   endtask

   // Opening pixels of a new frame: hsync and vsync fall together.
   task automatic sendTail();
      repeat (HSW) drivePixel(8'h00);
   endtask

   // Emit one frame from the table, then close it and check the report.
   task automatic applyStimulus(input vec_t v, input int idx);
      int fv0;
      int le0;
      int len;
      logic [7:0]  px;
      logic [15:0] expCrc;
      fv0      = fvCount;
      le0      = leCount;
      modelCrc = 16'hFFFF;
      for (int ln = 0; ln < v.lines; ln++) begin
         len = (ln == v.oddLine) ? v.oddLen : HT;
         for (int pos = (ln == 0) ? HSW : 0; pos < len; pos++) begin
            px = pixelAt(ln, pos, v);
            if (isActive(ln, pos)) modelCrc = crcPixel(modelCrc, px);
            drivePixel(px);
         end
      end
      sendTail();
      expCrc       = CrcOn ? modelCrc : 16'h0000;
      crcSeen[idx] = frame_crc;
      checkOutput($sformatf("v%0d frame_valid count", idx), 32'(fvCount - fv0), 32'd1);
      checkOutput($sformatf("v%0d frame_lines", idx), lastLines, 32'(v.expLines));
      checkOutput($sformatf("v%0d frame_crc", idx), lastCrc, 32'(expCrc));
      checkOutput($sformatf("v%0d err_sticky", idx), 32'(err_sticky), 32'(v.expSticky));
      checkOutput($sformatf("v%0d line_err count", idx), 32'(leCount - le0), 32'(v.expErrs));
      checkOutput($sformatf("v%0d line_len", idx), 32'(line_len), 32'(HT));
      checkOutput($sformatf("v%0d hsync_w", idx), 32'(hsync_w), 32'(HSW));
      checkOutput($sformatf("v%0d vsync_w", idx), 32'(vsync_w), 32'(VSW));
      checkOutput($sformatf("v%0d locked", idx), 32'(locked), 32'd1);
      if (v.expErrs > 0) begin
         checkOutput($sformatf("v%0d line_len at line_err", idx), lastErrLen, 32'(v.expErrLen));
      end
   endtask

   task automatic runVectors(input int first, input int last);
      for (int i = first; i <= last; i++) applyStimulus(vecs[i], i);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " locked"},      32'(locked),      32'd0);
      checkOutput({tag, " line_len"},    32'(line_len),    32'd0);
      checkOutput({tag, " hsync_w"},     32'(hsync_w),     32'd0);
      checkOutput({tag, " frame_lines"}, 32'(frame_lines), 32'd0);
      checkOutput({tag, " vsync_w"},     32'(vsync_w),     32'd0);
      checkOutput({tag, " frame_crc"},   32'(frame_crc),   32'd0);
      checkOutput({tag, " frame_valid"}, 32'(frame_valid), 32'd0);
      checkOutput({tag, " line_err"},    32'(line_err),    32'd0);
      checkOutput({tag, " err_sticky"},  32'(err_sticky),  32'd0);
   endtask

   initial begin
      int         fvLock;
      logic [7:0] px;
      vec_t       nominal;

      // lines, oddLine, oddLen, whiteX, whiteY, noise, expLines, expSticky, expErrs, expErrLen
      vecs[0] = '{VT, -1, 0,    -1, -1, 0, VT,     0, 0, 0};     // all-black frame
      vecs[1] = '{VT, -1, 0,    HS, VS, 0, VT,     0, 0, 0};     // one white pixel at first active spot
      vecs[2] = '{VT, -1, 0,    -1, -1, 1, VT,     0, 0, 0};     // black active, lit blanking
      vecs[3] = '{VT - 1, -1, 0, -1, -1, 0, VT - 1, 1, 0, 0};    // frame one line short
      vecs[4] = '{VT, -1, 0,    -1, -1, 0, VT,     0, 0, 0};     // first report after mid-frame reset
      vecs[5] = '{VT, 7, HT - 1, -1, -1, 0, VT,    1, 1, HT - 1}; // one line one clock short
      vecs[6] = '{VT, 3, HSW + 3000, -1, -1, 0, VT, 1, 1, 2047}; // HS stalled high for 3000 clocks
      nominal = vecs[0];

      // Power-on reset: every output must read zero.
      rst_n  = 1'b0;
      vga_in = 8'h00;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;

      // Idle with both syncs high, then the first vsync fall locks the checker
      // without producing a report.
      repeat (8) drivePixel(8'h88);
      checkOutput("pre-lock locked", 32'(locked), 32'd0);
      fvLock = fvCount;
      sendTail();
      checkOutput("lock locked", 32'(locked), 32'd1);
      checkOutput("lock no frame_valid", 32'(fvCount - fvLock), 32'd0);

      runVectors(0, 3);

`ifdef VGA_CHECK_CRC_EN
      checkOutput("crc white differs from black", 32'(crcSeen[1] != crcSeen[0]), 32'd1);
`endif

      // Mid-frame asynchronous reset, released while the frame carries on.
      // Locking must wait for the next vsync fall, and that boundary must not
      // report the partial frame.
      for (int idx = HSW; idx < VT * HT; idx++) begin
         px = pixelAt(idx / HT, idx % HT, nominal);
         drivePixel(px);
         if (idx == 250) begin
            #2 rst_n = 1'b0;
            #1 checkAllZero("mid-frame reset");
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      checkOutput("post-reset locked before vfall", 32'(locked), 32'd0);
      fvLock = fvCount;
      sendTail();
      checkOutput("post-reset locked after vfall", 32'(locked), 32'd1);
      checkOutput("post-reset no frame_valid at lock", 32'(fvCount - fvLock), 32'd0);

      runVectors(4, 6);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
